// File: rtl/gdc_pkg.sv
// Shared definitions for the garage door plant model.
//   plant_state_t : 2-bit plant state encoding (STOPPED, RAISING, LOWERING, FAULT)
//   FLT_*         : fault_code values reported on the fault_code output
package gdc_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'b00,
    RAISING  = 2'b01,
    LOWERING = 2'b10,
    FAULT    = 2'b11
  } plant_state_t;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_BOTH = 2'b01;
  localparam logic [1:0] FLT_OVR  = 2'b10;

endpackage

// File: rtl/gdc_step_timer.sv
// Step prescaler for the door plant.
// Counts clocks while enabled and emits a one-cycle step pulse at terminal
// count (every STEP_DIV counting clocks).
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clr   : forces the count to zero (also means "not counting")
//   hold  : freezes the count and suppresses the step pulse
//   step  : terminal-count pulse, combinational from count and controls
module gdc_step_timer #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic step
);

  // A divide-by-one still needs a 1-bit register; its count simply stays 0.
  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             tc;

  assign tc   = (cnt_reg == LAST);
  assign step = !clr && !hold && tc;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (!hold) begin
      cnt_reg <= tc ? '0 : cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gdc_door_plant.sv
// Garage door mechanism plant: integrates door position from the motor
// commands and reports the limit switches back to the controller.
//   clk, rst     : clock and synchronous active-high reset
//   UP_M, DN_M   : raise / lower motor commands
//   stall        : obstruction, freezes motion while high
//   UP_Max       : open limit (position == TRAVEL)
//   DN_Max       : closed limit (position == 0)
//   position     : current door position
//   moving       : door actually travelling this cycle
//   fault        : sticky fault, cleared only by rst
//   fault_code   : first fault cause (FLT_BOTH / FLT_OVR)
module gdc_door_plant
  import gdc_pkg::*;
#(
  parameter int POS_W     = 8,
  parameter int TRAVEL    = 200,
  parameter int STEP_DIV  = 4,
  parameter int OVR_LIMIT = 8,
  parameter int INIT_OPEN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             UP_M,
  input  logic             DN_M,
  input  logic             stall,
  output logic             UP_Max,
  output logic             DN_Max,
  output logic [POS_W-1:0] position,
  output logic             moving,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam logic [POS_W-1:0] TOP_POS   = POS_W'(TRAVEL);
  localparam logic [POS_W-1:0] NEAR_TOP  = POS_W'(TRAVEL - 1);
  localparam logic [POS_W-1:0] NEAR_BOT  = POS_W'(1);
  localparam logic [POS_W-1:0] RESET_POS = (INIT_OPEN != 0) ? TOP_POS : '0;
  localparam int               OVR_W     = $clog2(OVR_LIMIT + 1);
  localparam logic [OVR_W-1:0] OVR_LAST  = OVR_W'(OVR_LIMIT - 1);

  plant_state_t     state_reg, state_next;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic [OVR_W-1:0] ovr_reg, ovr_next;
  logic [1:0]       code_reg, code_next;

  logic at_top, at_bot, run, step;

  assign at_top = (pos_reg == TOP_POS);
  assign at_bot = (pos_reg == '0);

  // The prescaler only runs while the current direction's command is held
  // alone; any stop, reversal or fault clears it so no partial step survives.
  assign run = ((state_reg == RAISING)  && UP_M && !DN_M) ||
               ((state_reg == LOWERING) && DN_M && !UP_M);

  gdc_step_timer #(
    .STEP_DIV(STEP_DIV)
  ) u_step_timer (
    .clk (clk),
    .rst (rst),
    .clr (!run),
    .hold(stall),
    .step(step)
  );

  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    ovr_next   = '0;
    code_next  = code_reg;
    if (state_reg != FAULT) begin
      if (UP_M && DN_M) begin
        state_next = FAULT;
        code_next  = FLT_BOTH;
      end else begin
        case (state_reg)
          STOPPED: begin
            // Pushing against a limit is tolerated for a short tail only.
            if ((UP_M && at_top) || (DN_M && at_bot)) begin
              if (ovr_reg == OVR_LAST) begin
                state_next = FAULT;
                code_next  = FLT_OVR;
              end else begin
                ovr_next = ovr_reg + OVR_W'(1);
              end
            end else if (UP_M) begin
              state_next = RAISING;
            end else if (DN_M) begin
              state_next = LOWERING;
            end
          end
          RAISING: begin
            if (!UP_M) begin
              state_next = STOPPED;
            end else if (step) begin
              pos_next = pos_reg + POS_W'(1);
              if (pos_reg == NEAR_TOP) state_next = STOPPED;
            end
          end
          LOWERING: begin
            if (!DN_M) begin
              state_next = STOPPED;
            end else if (step) begin
              pos_next = pos_reg - POS_W'(1);
              if (pos_reg == NEAR_BOT) state_next = STOPPED;
            end
          end
          default: state_next = FAULT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= STOPPED;
      pos_reg   <= RESET_POS;
      ovr_reg   <= '0;
      code_reg  <= FLT_NONE;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      ovr_reg   <= ovr_next;
      code_reg  <= code_next;
    end
  end

  assign UP_Max     = at_top;
  assign DN_Max     = at_bot;
  assign position   = pos_reg;
  assign moving     = ((state_reg == RAISING) || (state_reg == LOWERING)) && !stall;
  assign fault      = (state_reg == FAULT);
  assign fault_code = code_reg;

endmodule
